video_timing_gen: RTL and testbench

- Raster timing generator that sits directly upstream of the sprite/paddle object stages and the HDMI/TMDS encoder.
- Produces the signed pixel coordinates (hpos, vpos) that objects compare against their bounding boxes.
- Produces the once-per-frame fsync strobe that objects use to advance their motion.
- Produces hsync, vsync and data-enable for the encoder.
- Defaults are CEA 720p60 (1650 x 750 total, 74.25 MHz pixel clock).

---
 rtl/video_timing_gen.sv | 96 +++++++++
 tb/tb_video_timing_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: signed pixel coordinates, syncs, data enable,
// per-frame strobe and frame counter. Every output comes straight from a flop.
module video_timing_gen #(
  parameter int unsigned HRES   = 1280,
  parameter int unsigned HFP    = 110,
  parameter int unsigned HSYNC  = 40,
  parameter int unsigned HBP    = 220,
  parameter int unsigned VRES   = 720,
  parameter int unsigned VFP    = 5,
  parameter int unsigned VSYNC  = 5,
  parameter int unsigned VBP    = 20,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               rst,
  output logic signed [11:0] hpos,
  output logic signed [11:0] vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               fsync,
  output logic [7:0]         frame_cnt
);

  localparam int unsigned CW = 12;
  localparam int unsigned FW = 8;

  // Coordinates run from the (negative) start of blanking up to the last active pixel.
  localparam logic signed [CW-1:0] H_START  = CW'(-int'(HFP + HSYNC + HBP));
  localparam logic signed [CW-1:0] H_LAST   = CW'(HRES - 1);
  localparam logic signed [CW-1:0] HS_BEG   = CW'(-int'(HSYNC + HBP));
  localparam logic signed [CW-1:0] HS_END   = CW'(-int'(HBP) - 1);
  localparam logic signed [CW-1:0] V_START  = CW'(-int'(VFP + VSYNC + VBP));
  localparam logic signed [CW-1:0] V_LAST   = CW'(VRES - 1);
  localparam logic signed [CW-1:0] VS_BEG   = CW'(-int'(VSYNC + VBP));
  localparam logic signed [CW-1:0] VS_END   = CW'(-int'(VBP) - 1);
  localparam logic signed [CW-1:0] ONE      = CW'(1);

  logic signed [CW-1:0] h_nxt;
  logic signed [CW-1:0] v_nxt;
  logic                 h_wrap;
  logic                 f_wrap;
  logic                 hs_nxt;
  logic                 vs_nxt;
  logic                 de_nxt;

  // Next raster position and the output levels that belong to it.
  always_comb begin
    h_nxt  = hpos + ONE;
    v_nxt  = vpos;
    h_wrap = 1'b0;
    f_wrap = 1'b0;
    if (hpos == H_LAST) begin
      h_wrap = 1'b1;
      h_nxt  = H_START;
      if (vpos == V_LAST) begin
        f_wrap = 1'b1;
        v_nxt  = V_START;
      end else begin
        v_nxt = vpos + ONE;
      end
    end
    hs_nxt = ((h_nxt >= HS_BEG) && (h_nxt <= HS_END)) ? HS_POL : ~HS_POL;
    vs_nxt = ((v_nxt >= VS_BEG) && (v_nxt <= VS_END)) ? VS_POL : ~VS_POL;
    de_nxt = ~h_nxt[CW-1] & ~v_nxt[CW-1];
  end

  // Output registers; reset parks the raster at the start of frame blanking.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hpos      <= H_START;
      vpos      <= V_START;
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
      de        <= 1'b0;
      fsync     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      hpos      <= h_nxt;
      vpos      <= v_nxt;
      hsync     <= hs_nxt;
      vsync     <= vs_nxt;
      de        <= de_nxt;
      fsync     <= f_wrap;
      if (f_wrap) begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // h_wrap is kept as a named term for readability of the wrap logic.
  logic unused_ok;
  assign unused_ok = h_wrap;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: two reduced-size instances (normal and
// inverted sync polarity) checked every cycle against a cycle-count timing model.
module tb_video_timing_gen;

  typedef struct {
    int hpos;
    int vpos;
    bit hs;
    bit vs;
    bit de;
    bit fs;
    int fc;
  } exp_t;

  // Instance A geometry (positive syncs)
  localparam int A_HRES = 16, A_HFP = 3, A_HS = 4, A_HBP = 5;
  localparam int A_VRES = 6,  A_VFP = 2, A_VS = 3, A_VBP = 4;
  // Instance B geometry (inverted syncs), small enough to wrap frame_cnt
  localparam int B_HRES = 8, B_HFP = 2, B_HS = 2, B_HBP = 2;
  localparam int B_VRES = 4, B_VFP = 2, B_VS = 2, B_VBP = 2;
  localparam int B_FRAME = (B_HRES + B_HFP + B_HS + B_HBP) * (B_VRES + B_VFP + B_VS + B_VBP);
  localparam int A_FRAME = (A_HRES + A_HFP + A_HS + A_HBP) * (A_VRES + A_VFP + A_VS + A_VBP);

  logic pixel_clk = 1'b0;
  logic rst = 1'b1;

  logic signed [11:0] a_hpos, a_vpos, b_hpos, b_vpos;
  logic a_hsync, a_vsync, a_de, a_fsync, b_hsync, b_vsync, b_de, b_fsync;
  logic [7:0] a_fc, b_fc;

  int total = 0;
  int bad = 0;
  int t = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 pixel_clk = ~pixel_clk;

  video_timing_gen #(
    .HRES(A_HRES), .HFP(A_HFP), .HSYNC(A_HS), .HBP(A_HBP),
    .VRES(A_VRES), .VFP(A_VFP), .VSYNC(A_VS), .VBP(A_VBP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_a (
    .pixel_clk(pixel_clk), .rst(rst), .hpos(a_hpos), .vpos(a_vpos),
    .hsync(a_hsync), .vsync(a_vsync), .de(a_de), .fsync(a_fsync), .frame_cnt(a_fc)
  );

  video_timing_gen #(
    .HRES(B_HRES), .HFP(B_HFP), .HSYNC(B_HS), .HBP(B_HBP),
    .VRES(B_VRES), .VFP(B_VFP), .VSYNC(B_VS), .VBP(B_VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_b (
    .pixel_clk(pixel_clk), .rst(rst), .hpos(b_hpos), .vpos(b_vpos),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .fsync(b_fsync), .frame_cnt(b_fc)
  );

  // Expected outputs after tt clock edges since reset release.
  function automatic exp_t model(input int tt, input int hres, input int hfp, input int hsw,
                                 input int hbp, input int vres, input int vfp, input int vsw,
                                 input int vbp, input bit hpol, input bit vpol);
    exp_t e;
    int htot, vtot, ftot, hi, li;
    htot   = hres + hfp + hsw + hbp;
    vtot   = vres + vfp + vsw + vbp;
    ftot   = htot * vtot;
    hi     = tt % htot;
    li     = (tt / htot) % vtot;
    e.hpos = hi - (hfp + hsw + hbp);
    e.vpos = li - (vfp + vsw + vbp);
    e.hs   = (hi >= hfp && hi < hfp + hsw) ? hpol : !hpol;
    e.vs   = (li >= vfp && li < vfp + vsw) ? vpol : !vpol;
    e.de   = (e.hpos >= 0) && (e.vpos >= 0);
    e.fs   = (tt > 0) && (tt % ftot == 0);
    e.fc   = (tt / ftot) % 256;
    return e;
  endfunction

  function automatic exp_t model_a(input int tt);
    return model(tt, A_HRES, A_HFP, A_HS, A_HBP, A_VRES, A_VFP, A_VS, A_VBP, 1'b1, 1'b1);
  endfunction

  function automatic exp_t model_b(input int tt);
    return model(tt, B_HRES, B_HFP, B_HS, B_HBP, B_VRES, B_VFP, B_VS, B_VBP, 1'b0, 1'b0);
  endfunction

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      if (bad <= 20) $display("FAIL %s t=%0d got=%0d want=%0d", tag, t, got, want);
    end
  endtask

  task automatic check_a(input string ph);
    exp_t e;
    e = q_a.pop_front();
    check({ph, " a.hpos"}, int'(a_hpos), e.hpos);
    check({ph, " a.vpos"}, int'(a_vpos), e.vpos);
    check({ph, " a.hsync"}, int'(a_hsync), int'(e.hs));
    check({ph, " a.vsync"}, int'(a_vsync), int'(e.vs));
    check({ph, " a.de"}, int'(a_de), int'(e.de));
    check({ph, " a.fsync"}, int'(a_fsync), int'(e.fs));
    check({ph, " a.frame_cnt"}, int'(a_fc), e.fc);
  endtask

  task automatic check_b(input string ph);
    exp_t e;
    e = q_b.pop_front();
    check({ph, " b.hpos"}, int'(b_hpos), e.hpos);
    check({ph, " b.vpos"}, int'(b_vpos), e.vpos);
    check({ph, " b.hsync"}, int'(b_hsync), int'(e.hs));
    check({ph, " b.vsync"}, int'(b_vsync), int'(e.vs));
    check({ph, " b.de"}, int'(b_de), int'(e.de));
    check({ph, " b.fsync"}, int'(b_fsync), int'(e.fs));
    check({ph, " b.frame_cnt"}, int'(b_fc), e.fc);
  endtask

  // One clock: expectation queued at the edge, DUT compared on the falling edge.
  task automatic step(input string ph);
    @(posedge pixel_clk);
    if (!rst) t++;
    q_a.push_back(model_a(t));
    q_b.push_back(model_b(t));
    @(negedge pixel_clk);
    check_a(ph);
    check_b(ph);
  endtask

  initial begin
    int n;
    bit found;
    // Power-up reset
    rst = 1'b1;
    t   = 0;
    for (int i = 0; i < 3; i++) step("reset");

    // Release away from the edge, then run past 256 frames of instance B
    rst = 1'b0;
    for (int i = 0; i < 256 * B_FRAME + 5; i++) step("run");

    // Seek into active video of instance A, bounded
    found = 1'b0;
    n = 0;
    while (!found && n < 4 * A_FRAME) begin
      step("seek");
      n++;
      if (model_a(t).de && model_a(t).hpos >= 5 && model_a(t).vpos >= 2) found = 1'b1;
    end
    check("seek_active", int'(found), 1);

    // Mid-frame reset: outputs must be at reset values before the next edge
    rst = 1'b1;
    #1;
    t = 0;
    q_a.push_back(model_a(0));
    q_b.push_back(model_b(0));
    check_a("async_rst");
    check_b("async_rst");
    for (int i = 0; i < 2; i++) step("hold_rst");

    // Timing after release must replay the power-up case with no stray fsync
    @(negedge pixel_clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * A_FRAME + 3; i++) step("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
